// File: rtl/prog_load_selftest.sv
// prog_load_selftest: program loader and result checker for the MEST-Pro core.
//
// Copies up to DEPTH words from a synchronous ROM into CPU instruction memory
// while holding the CPU in reset, and accumulates a checksum of the accepted words.
// It then releases the CPU for a programmable cycle budget and compares the CPU
// result register against an expected value.
//
// Ports:
//   clk, s_reset_n    clock, synchronous active-low reset
//   start             synchronised start level; its rising edge requests a run
//   load_len          words to load (0 skips the load, clamped to DEPTH)
//   timeout           RUN length in cycles (0 behaves as 1)
//   expected          value the CPU result must reach
//   rom_addr/rom_data program ROM read port (1-cycle latency)
//   mem_wr_*          valid/ready write port into CPU instruction memory
//   cpu_hold          CPU reset, high while loading
//   result            CPU output register
//   busy/done         progress flags
//   pass/fail         verdict, valid while done is high
//   checksum          sum mod 2^DATA_W of all accepted write data
module prog_load_selftest #(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned ADDR_W     = 8,
    parameter int unsigned DEPTH      = 256,
    parameter int unsigned TMO_W      = 16,
    parameter bit          EARLY_EXIT = 1'b0
) (
    input  logic              clk,
    input  logic              s_reset_n,
    input  logic              start,
    input  logic [ADDR_W:0]   load_len,
    input  logic [TMO_W-1:0]  timeout,
    input  logic [DATA_W-1:0] expected,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic              mem_wr_valid,
    input  logic              mem_wr_ready,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic [DATA_W-1:0] mem_wr_data,
    output logic              cpu_hold,
    input  logic [DATA_W-1:0] result,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              fail,
    output logic [DATA_W-1:0] checksum
);

    typedef enum logic [2:0] {StIdle, StFetch, StWrite, StRun, StCheck, StDone} state_e;

    localparam logic [ADDR_W:0] DepthLen = (ADDR_W + 1)'(DEPTH);

    state_e            state;
    logic              start_q;
    logic [ADDR_W-1:0] idx;
    logic [ADDR_W:0]   len;
    logic [TMO_W-1:0]  cnt;

    logic              go;
    logic [ADDR_W:0]   len_clamped;
    logic [TMO_W-1:0]  tmo_last;
    logic              hit;
    logic              last_word;
    logic              accept;

    assign go          = start & ~start_q;
    assign len_clamped = (load_len > DepthLen) ? DepthLen : load_len;
    assign tmo_last    = (timeout == '0) ? '0 : timeout - 1'b1;
    assign hit         = (result == expected);
    // Compared one bit wider so that idx never has to reach 2^ADDR_W.
    assign last_word   = ({1'b0, idx} == len - 1'b1);
    assign accept      = mem_wr_valid & mem_wr_ready;

    // The ROM address is held through WRITE, so its output is stable for the
    // whole handshake; gating with valid keeps the port quiet otherwise.
    assign mem_wr_data = mem_wr_valid ? rom_data : '0;

    always_ff @(posedge clk) begin
        if (!s_reset_n) begin
            state        <= StIdle;
            start_q      <= 1'b1;  // a start held through reset is not a request
            idx          <= '0;
            len          <= '0;
            cnt          <= '0;
            rom_addr     <= '0;
            mem_wr_valid <= 1'b0;
            mem_wr_addr  <= '0;
            cpu_hold     <= 1'b1;
            busy         <= 1'b0;
            done         <= 1'b0;
            pass         <= 1'b0;
            fail         <= 1'b0;
            checksum     <= '0;
        end else begin
            start_q <= start;
            unique case (state)
                StIdle, StDone: begin
                    if (go) begin
                        idx      <= '0;
                        checksum <= '0;
                        pass     <= 1'b0;
                        fail     <= 1'b0;
                        done     <= 1'b0;
                        busy     <= 1'b1;
                        cnt      <= '0;
                        len      <= len_clamped;
                        rom_addr <= '0;
                        if (len_clamped != '0) begin
                            cpu_hold <= 1'b1;
                            state    <= StFetch;
                        end else begin
                            cpu_hold <= 1'b0;
                            state    <= StRun;
                        end
                    end
                end
                StFetch: begin
                    mem_wr_valid <= 1'b1;
                    mem_wr_addr  <= idx;
                    state        <= StWrite;
                end
                StWrite: begin
                    if (accept) begin
                        checksum     <= checksum + mem_wr_data;
                        mem_wr_valid <= 1'b0;
                        if (last_word) begin
                            cpu_hold <= 1'b0;
                            state    <= StRun;
                        end else begin
                            idx      <= idx + 1'b1;
                            rom_addr <= idx + 1'b1;
                            state    <= StFetch;
                        end
                    end
                end
                StRun: begin
                    if (EARLY_EXIT && hit) begin
                        pass  <= 1'b1;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= StDone;
                    end else if (cnt == tmo_last) begin
                        state <= StCheck;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                StCheck: begin
                    pass  <= hit;
                    fail  <= ~hit;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= StDone;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_prog_load_selftest.sv
// Self-checking bench for prog_load_selftest. Instance a uses the timeout path,
// instance b has EARLY_EXIT enabled. Expected timing, checksum, write stream and
// verdict come from plain arithmetic over the ROM image.
module tb_prog_load_selftest;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        s_reset_n;
    logic        start, start_b;
    logic [8:0]  load_len;
    logic [15:0] timeout, expected, result, result_b;
    logic [7:0]  rom_addr, rom_addr_b, mem_wr_addr, addr_b;
    logic [15:0] rom_data = '0, rom_data_b = '0;
    logic        mem_wr_valid, mem_wr_ready, valid_b, ready_b;
    logic [15:0] mem_wr_data, data_b, checksum, checksum_b;
    logic        cpu_hold, busy, done, pass, fail;
    logic        hold_b, busy_b, done_b, pass_b, fail_b;

    logic [15:0] rom [256];

    int total = 0;
    int bad   = 0;

    prog_load_selftest dut_a (
        .clk(clk), .s_reset_n(s_reset_n), .start(start), .load_len(load_len),
        .timeout(timeout), .expected(expected), .rom_addr(rom_addr), .rom_data(rom_data),
        .mem_wr_valid(mem_wr_valid), .mem_wr_ready(mem_wr_ready), .mem_wr_addr(mem_wr_addr),
        .mem_wr_data(mem_wr_data), .cpu_hold(cpu_hold), .result(result), .busy(busy),
        .done(done), .pass(pass), .fail(fail), .checksum(checksum)
    );

    prog_load_selftest #(.EARLY_EXIT(1'b1)) dut_b (
        .clk(clk), .s_reset_n(s_reset_n), .start(start_b), .load_len(load_len),
        .timeout(timeout), .expected(expected), .rom_addr(rom_addr_b), .rom_data(rom_data_b),
        .mem_wr_valid(valid_b), .mem_wr_ready(ready_b), .mem_wr_addr(addr_b),
        .mem_wr_data(data_b), .cpu_hold(hold_b), .result(result_b), .busy(busy_b),
        .done(done_b), .pass(pass_b), .fail(fail_b), .checksum(checksum_b)
    );

    // Synchronous ROMs with one cycle of read latency.
    always @(posedge clk) rom_data   <= rom[rom_addr];
    always @(posedge clk) rom_data_b <= rom[rom_addr_b];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Accepted-write log and stall stability checks.
    logic [7:0]  wq_addr[$];
    logic [15:0] wq_data[$];
    logic        stalled_prev = 1'b0;
    logic [7:0]  st_addr = '0;
    logic [15:0] st_data = '0;

    always @(posedge clk) begin
        if (s_reset_n && mem_wr_valid && stalled_prev) begin
            chk("stall_addr_stable", {24'h0, mem_wr_addr}, {24'h0, st_addr});
            chk("stall_data_stable", {16'h0, mem_wr_data}, {16'h0, st_data});
        end
        if (s_reset_n && mem_wr_valid && mem_wr_ready) begin
            wq_addr.push_back(mem_wr_addr);
            wq_data.push_back(mem_wr_data);
        end
        stalled_prev <= s_reset_n && mem_wr_valid && !mem_wr_ready;
        st_addr      <= mem_wr_addr;
        st_data      <= mem_wr_data;
    end

    // Ready driver: withholds ready for stall_n cycles on address stall_at.
    int stall_at = -1;
    int stall_n  = 0;
    int stall_cnt = 0;

    initial begin
        mem_wr_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (!mem_wr_valid) stall_cnt = 0;
            if (mem_wr_valid && int'(mem_wr_addr) == stall_at && stall_cnt < stall_n) begin
                mem_wr_ready = 1'b0;
                stall_cnt++;
            end else begin
                mem_wr_ready = 1'b1;
            end
        end
    end

    task automatic run_a(input int len_in, input int tmo, input int s_at, input int s_n,
                         input logic [15:0] exp_v, input logic [15:0] res_v);
        int n_words, t_eff, s_eff, exp_done, n, hold_at;
        logic [15:0] sum;
        n_words = (len_in > 256) ? 256 : len_in;
        t_eff   = (tmo == 0) ? 1 : tmo;
        s_eff   = (s_at >= 0 && s_at < n_words) ? s_n : 0;
        sum     = '0;
        for (int i = 0; i < n_words; i++) sum = sum + rom[i];
        exp_done = 2 * n_words + s_eff + t_eff + 2;

        @(negedge clk);
        load_len = 9'(len_in);
        timeout  = 16'(tmo);
        expected = exp_v;
        result   = res_v;
        stall_at = s_at;
        stall_n  = s_n;
        wq_addr.delete();
        wq_data.delete();
        start    = 1'b1;

        n = 0;
        hold_at = -1;
        while (n < exp_done + 20) begin
            @(negedge clk);
            n++;
            if (n == 1) chk("busy_after_go", {31'h0, busy}, 32'd1);
            if (hold_at < 0 && !cpu_hold) hold_at = n;
            if (done) break;
        end
        chk("done_cycle", n, exp_done);
        chk("hold_release_cycle", hold_at, 2 * n_words + s_eff + 1);
        chk("pass", {31'h0, pass}, {31'h0, res_v == exp_v});
        chk("fail", {31'h0, fail}, {31'h0, res_v != exp_v});
        chk("busy_at_done", {31'h0, busy}, 32'd0);
        chk("checksum", {16'h0, checksum}, {16'h0, sum});
        chk("write_count", wq_addr.size(), n_words);
        for (int i = 0; i < n_words && i < wq_addr.size(); i++) begin
            chk("wr_addr", {24'h0, wq_addr[i]}, i);
            chk("wr_data", {16'h0, wq_data[i]}, {16'h0, rom[i]});
        end
        start   = 1'b0;
        stall_n = 0;
        repeat (3) @(negedge clk);
        chk("done_holds", {31'h0, done}, 32'd1);
        chk("checksum_holds", {16'h0, checksum}, {16'h0, sum});
    endtask

    initial begin
        int n;
        logic [15:0] e;

        for (int i = 0; i < 256; i++) rom[i] = 16'($urandom);
        rom[0] = 16'h0001; rom[1] = 16'h0002; rom[2] = 16'h0003; rom[3] = 16'h0004;

        s_reset_n = 1'b0;
        start = 1'b0; start_b = 1'b0;
        load_len = '0; timeout = '0; expected = '0; result = '0; result_b = '0;
        ready_b = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_cpu_hold", {31'h0, cpu_hold}, 32'd1);
        chk("rst_valid",    {31'h0, mem_wr_valid}, 32'd0);
        chk("rst_busy",     {31'h0, busy}, 32'd0);
        chk("rst_done",     {31'h0, done}, 32'd0);
        chk("rst_pass_fail", {30'h0, pass, fail}, 32'd0);
        chk("rst_rom_addr", {24'h0, rom_addr}, 32'd0);
        chk("rst_checksum", {16'h0, checksum}, 32'd0);
        s_reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Directed runs: match, mismatch, stall, empty, oversize, zero timeout.
        run_a(4, 10, -1, 0, 16'h0277, 16'h0277);
        run_a(4, 10, -1, 0, 16'h0277, 16'h0276);
        run_a(4, 10, 2, 3, 16'h1234, 16'h1234);
        run_a(0, 7, -1, 0, 16'h00aa, 16'h00aa);
        run_a(300, 3, -1, 0, 16'h5555, 16'h5554);
        run_a(4, 0, -1, 0, 16'hbeef, 16'hbeef);

        // Random runs.
        for (int k = 0; k < 6; k++) begin
            e = 16'($urandom);
            run_a(int'($urandom_range(20, 0)), int'($urandom_range(15, 0)),
                  int'($urandom_range(5, 0)), int'($urandom_range(4, 0)),
                  e, ($urandom_range(1, 0) == 1) ? e : e ^ 16'($urandom_range(255, 1)));
        end

        // Early exit: result matches in the third RUN cycle of a 2-word load.
        @(negedge clk);
        load_len = 9'd2;
        timeout  = 16'd1000;
        expected = 16'h0c0d;
        result_b = 16'hf3f2;
        start_b  = 1'b1;
        n = 0;
        while (n < 40) begin
            @(negedge clk);
            n++;
            if (n == 2 * 2 + 3) result_b = 16'h0c0d;
            if (done_b) break;
        end
        chk("early_done_cycle", n, 2 * 2 + 4);
        chk("early_pass", {31'h0, pass_b}, 32'd1);
        chk("early_fail", {31'h0, fail_b}, 32'd0);
        chk("early_checksum", {16'h0, checksum_b}, {16'h0, 16'(rom[0] + rom[1])});
        start_b = 1'b0;

        // Reset during a stalled write with start held high across release.
        @(negedge clk);
        load_len = 9'd4;
        timeout  = 16'd5;
        stall_at = 1;
        stall_n  = 1000;
        start    = 1'b1;
        n = 0;
        while (n < 20 && !(mem_wr_valid && mem_wr_addr == 8'd1)) begin
            @(negedge clk);
            n++;
        end
        chk("reached_word1_write", {31'h0, mem_wr_valid && mem_wr_addr == 8'd1}, 32'd1);
        s_reset_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_cpu_hold", {31'h0, cpu_hold}, 32'd1);
        chk("mid_rst_valid", {31'h0, mem_wr_valid}, 32'd0);
        chk("mid_rst_busy_done", {30'h0, busy, done}, 32'd0);
        chk("mid_rst_pass_fail", {30'h0, pass, fail}, 32'd0);
        chk("mid_rst_addrs", {16'h0, rom_addr, mem_wr_addr}, 32'd0);
        chk("mid_rst_wdata", {16'h0, mem_wr_data}, 32'd0);
        chk("mid_rst_checksum", {16'h0, checksum}, 32'd0);
        stall_n = 0;
        @(negedge clk);
        s_reset_n = 1'b1;
        wq_addr.delete();
        wq_data.delete();
        repeat (6) @(negedge clk);
        chk("no_run_after_rst_busy", {31'h0, busy}, 32'd0);
        chk("no_run_after_rst_hold", {31'h0, cpu_hold}, 32'd1);
        chk("no_run_after_rst_writes", wq_addr.size(), 0);
        start = 1'b0;
        run_a(3, 4, -1, 0, 16'h7777, 16'h7777);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/prog_load_selftest.md
# prog_load_selftest

On-chip program loader and result checker for the MEST-Pro core. On a start request it holds the CPU in reset, copies a runtime-selectable number of words from a synchronous program ROM into CPU instruction memory over a valid/ready write port, and accumulates a checksum. It then releases the CPU, waits a programmable cycle budget, and compares the CPU output register against an expected value, flagging pass or fail. It sits in `asic_top` between the button synchroniser, the program ROM, the CPU memory write port and the LED drivers. It is a parametrised successor to the fixed-size, fixed-timeout bring-up flow.

## Interface
Parameters:
- `DATA_W`, 16, word width of ROM, memory write data, result and checksum.
- `ADDR_W`, 8, address width of ROM and memory.
- `DEPTH`, 256, maximum words loaded (≤ 2^ADDR_W).
- `TMO_W`, 16, width of the timeout budget.
- `EARLY_EXIT`, 0, when 1, pass as soon as `result == expected` during RUN.

Ports:
- `clk` in 1: single clock. All logic is on its rising edge.
- `s_reset_n` in 1: synchronous, active-low reset.
- `start` in 1: start level, already synchronised. Its rising edge is the request.
- `load_len` in ADDR_W+1: number of words to load. 0 skips the load. Values above DEPTH clamp to DEPTH.
- `timeout` in TMO_W: RUN duration in cycles. 0 is treated as 1.
- `expected` in DATA_W: expected final `result`.
- `rom_addr` out ADDR_W: ROM read address. The ROM has 1-cycle read latency.
- `rom_data` in DATA_W: ROM read data.
- `mem_wr_valid` out 1: write request.
- `mem_wr_ready` in 1: write accept.
- `mem_wr_addr` out ADDR_W: write address.
- `mem_wr_data` out DATA_W: write data.
- `cpu_hold` out 1: holds the CPU in reset while 1.
- `result` in DATA_W: CPU output register value.
- `busy` out 1: high in FETCH, WRITE, RUN and CHECK.
- `done` out 1: high in DONE.
- `pass` out 1: verdict, valid while `done` is high.
- `fail` out 1: verdict, valid while `done` is high.
- `checksum` out DATA_W: sum mod 2^DATA_W of all accepted write data.

## Operation
States: IDLE, FETCH, WRITE, RUN, CHECK, DONE.

Start detection:
- `start_q` is a register that resets to 1, so a `start` held high through reset does not trigger.
- `go = start & ~start_q`.

Transitions:
- IDLE, or DONE, on `go`:
  - Clear `idx`, `checksum`, `pass`, `fail` and the RUN counter.
  - Latch `len = min(load_len, DEPTH)`.
  - Go to FETCH if `len != 0`, otherwise go to RUN.
- FETCH: drive `rom_addr = idx`. Next state is WRITE.
- WRITE:
  - `mem_wr_valid = 1`, `mem_wr_addr = idx`, `mem_wr_data = rom_data`. The address is held from FETCH, so the ROM output is stable.
  - Address and data stay stable until accepted.
  - On `mem_wr_valid & mem_wr_ready`: `checksum += mem_wr_data`. If `idx == len-1`, go to RUN. Otherwise `idx++` and go to FETCH.
- RUN:
  - `cpu_hold = 0`. The counter increments each cycle.
  - When `counter == max(timeout,1) - 1`, go to CHECK.
  - If `EARLY_EXIT = 1` and `result == expected` in any RUN cycle, set `pass` and go straight to DONE.
- CHECK: set `pass = (result == expected)` and `fail = ~pass`, then go to DONE.
- DONE: flags and `checksum` hold. The CPU keeps running.

Other rules:
- `cpu_hold = 1` in IDLE, FETCH and WRITE. It is 0 in RUN, CHECK and DONE.
- `go` is ignored while `busy`.
- `idx` never wraps. With `len = DEPTH = 2^ADDR_W`, the last address is 2^ADDR_W−1 and the transition to RUN happens before any increment.
- The checksum wraps modulo 2^DATA_W.
- `pass` and `fail` are never both 1.

## Timing
Reset values:
- IDLE state.
- `cpu_hold` = 1.
- `mem_wr_valid`, `busy`, `done`, `pass`, `fail` = 0.
- `rom_addr`, `mem_wr_addr`, `mem_wr_data`, `checksum`, `idx` = 0.

Latency:
- With `mem_wr_ready` tied high, each word takes 2 cycles. An N-word load occupies 2N cycles from the cycle after `go`.
- Each low-ready cycle adds one cycle.
- RUN lasts exactly `max(timeout,1)` cycles unless the early exit fires.
- CHECK lasts 1 cycle. `done` rises the cycle after CHECK.

Other timing rules:
- All outputs are registered, except `mem_wr_data`, which passes `rom_data` through.
- `result` is sampled in the last RUN cycle's CHECK, i.e. on the CHECK-state clock edge.
- Reset mid-operation, including during a pending write, returns to reset values on the next edge. `mem_wr_valid` drops with no handshake completion.
- `go` in the same cycle as a reset is discarded.

## Test plan
- Load 4 words {0x0001,0x0002,0x0003,0x0004}, ready tied high, `timeout` = 10, `result` = 0x0277, `expected` = 0x0277. Required: 4 writes at addresses 0..3; `checksum` = 0x000A; `cpu_hold` low exactly 8 cycles after `go`+1; `pass` = 1, `done` = 1 at cycle 8+10+2.
- Same load with `result` = 0x0276. Required: `fail` = 1, `pass` = 0.
- Ready stalled 3 cycles on word 2. Required: address and data held stable while stalled; exactly 4 accepted writes; total load 11 cycles.
- `load_len` = 0 and `load_len` = 300 (DEPTH = 256). Required: 0 gives no writes, direct RUN, `checksum` = 0. 300 gives 256 writes ending at address 0xFF, no wrap.
- `EARLY_EXIT` = 1, `result` matches at RUN cycle 3 with `timeout` = 1000. Required: `done` and `pass` 1 cycle later.
- Reset asserted mid-WRITE, then `start` held high across reset release. Required: all outputs at reset values, and no new run until `start` falls and rises again.
